// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register: captures control word, ALU control and ID operands.
// Latency: exactly 1 cycle from D inputs to E outputs.
// Backpressure: StallE holds every E output; FlushE loads a bubble and takes priority over StallE.
//
// Ports:
//   clk, reset_n              rising-edge clock, asynchronous active-low reset (all outputs 0)
//   StallE, FlushE            hazard-unit controls
//   ValidD / ValidE           slot carries a real instruction (distinguishes bubbles from NOPs)
//   *D inputs -> *E outputs   control, ALU control, funct3, operands, PCs, immediate, reg indices
// Optional build macro IDEX_PERF_CNT_EN adds saturating BubbleCntE / StallCntE counters of width CNT_W.
module id_ex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 4
`ifdef IDEX_PERF_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic [2:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 BranchD,
    input  logic                 JumpD,
    input  logic                 ALUSrcD,
    input  logic                 PCResultSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [2:0]           funct3D,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdD,
    output logic                 ValidE,
    output logic                 RegWriteE,
    output logic [2:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic                 ALUSrcE,
    output logic                 PCResultSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [2:0]           funct3E,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [4:0]           Rs1E,
    output logic [4:0]           Rs2E,
    output logic [4:0]           RdE
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     BubbleCntE,
    output logic [CNT_W-1:0]     StallCntE
`endif
);

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic [2:0]           result_src;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 alu_src;
        logic                 pc_result_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [2:0]           funct3;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      imm_ext;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
    } ex_word_t;

    ex_word_t d_word;
    ex_word_t e_word;

    // Architectural side effects (register write, store, branch, jump) are
    // squashed for an invalid slot so it can never commit downstream. Other
    // fields, including decoder don't-cares, pass through untouched.
    always_comb begin
        d_word               = '0;
        d_word.valid         = ValidD;
        d_word.reg_write     = RegWriteD & ValidD;
        d_word.result_src    = ResultSrcD;
        d_word.mem_write     = MemWriteD & ValidD;
        d_word.branch        = BranchD & ValidD;
        d_word.jump          = JumpD & ValidD;
        d_word.alu_src       = ALUSrcD;
        d_word.pc_result_src = PCResultSrcD;
        d_word.alu_ctrl      = ALUControlD;
        d_word.funct3        = funct3D;
        d_word.rd1           = RD1D;
        d_word.rd2           = RD2D;
        d_word.pc            = PCD;
        d_word.pc_plus4      = PCPlus4D;
        d_word.imm_ext       = ImmExtD;
        d_word.rs1           = Rs1D;
        d_word.rs2           = Rs2D;
        d_word.rd            = RdD;
    end

    // Flush beats stall: a bubble is inserted even while the stage is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_word <= '0;
        end else if (FlushE) begin
            e_word <= '0;
        end else if (!StallE) begin
            e_word <= d_word;
        end
    end

    assign ValidE       = e_word.valid;
    assign RegWriteE    = e_word.reg_write;
    assign ResultSrcE   = e_word.result_src;
    assign MemWriteE    = e_word.mem_write;
    assign BranchE      = e_word.branch;
    assign JumpE        = e_word.jump;
    assign ALUSrcE      = e_word.alu_src;
    assign PCResultSrcE = e_word.pc_result_src;
    assign ALUControlE  = e_word.alu_ctrl;
    assign funct3E      = e_word.funct3;
    assign RD1E         = e_word.rd1;
    assign RD2E         = e_word.rd2;
    assign PCE          = e_word.pc;
    assign PCPlus4E     = e_word.pc_plus4;
    assign ImmExtE      = e_word.imm_ext;
    assign Rs1E         = e_word.rs1;
    assign Rs2E         = e_word.rs2;
    assign RdE          = e_word.rd;

`ifdef IDEX_PERF_CNT_EN
    // Saturating counters: a stall edge that is overridden by a flush counts
    // only as a bubble.
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (FlushE && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (StallE && !FlushE && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign BubbleCntE = bubble_cnt;
    assign StallCntE  = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, multi-cycle
// stall / async-reset sequences, randomized traffic against a reference model,
// and (with IDEX_PERF_CNT_EN) saturating counter checks at CNT_W=4.
module tb_id_ex_pipe_reg;

    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [2:0]  result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        pc_result_src;
        logic [3:0]  alu_ctrl;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    typedef struct {
        logic   stall;
        logic   flush;
        stage_t d;
        stage_t exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   stall;
    logic   flush;
    stage_t d;
    stage_t e_act;

    logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, PCResultSrcE;
    logic [2:0]  ResultSrcE, funct3E;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef IDEX_PERF_CNT_EN
    logic [3:0]  BubbleCntE, StallCntE;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: what the E stage must hold, plus expected counters.
    stage_t m;
    int     bub_m;
    int     stl_m;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .XLEN(32),
        .ALUCTRL_W(4)
`ifdef IDEX_PERF_CNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .StallE(stall),
        .FlushE(flush),
        .ValidD(d.valid),
        .RegWriteD(d.reg_write),
        .ResultSrcD(d.result_src),
        .MemWriteD(d.mem_write),
        .BranchD(d.branch),
        .JumpD(d.jump),
        .ALUSrcD(d.alu_src),
        .PCResultSrcD(d.pc_result_src),
        .ALUControlD(d.alu_ctrl),
        .funct3D(d.funct3),
        .RD1D(d.rd1),
        .RD2D(d.rd2),
        .PCD(d.pc),
        .PCPlus4D(d.pc_plus4),
        .ImmExtD(d.imm_ext),
        .Rs1D(d.rs1),
        .Rs2D(d.rs2),
        .RdD(d.rd),
        .ValidE(ValidE),
        .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE),
        .BranchE(BranchE),
        .JumpE(JumpE),
        .ALUSrcE(ALUSrcE),
        .PCResultSrcE(PCResultSrcE),
        .ALUControlE(ALUControlE),
        .funct3E(funct3E),
        .RD1E(RD1E),
        .RD2E(RD2E),
        .PCE(PCE),
        .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE),
        .Rs1E(Rs1E),
        .Rs2E(Rs2E),
        .RdE(RdE)
`ifdef IDEX_PERF_CNT_EN
        ,
        .BubbleCntE(BubbleCntE),
        .StallCntE(StallCntE)
`endif
    );

    always_comb begin
        e_act               = '0;
        e_act.valid         = ValidE;
        e_act.reg_write     = RegWriteE;
        e_act.result_src    = ResultSrcE;
        e_act.mem_write     = MemWriteE;
        e_act.branch        = BranchE;
        e_act.jump          = JumpE;
        e_act.alu_src       = ALUSrcE;
        e_act.pc_result_src = PCResultSrcE;
        e_act.alu_ctrl      = ALUControlE;
        e_act.funct3        = funct3E;
        e_act.rd1           = RD1E;
        e_act.rd2           = RD2E;
        e_act.pc            = PCE;
        e_act.pc_plus4      = PCPlus4E;
        e_act.imm_ext       = ImmExtE;
        e_act.rs1           = Rs1E;
        e_act.rs2           = Rs2E;
        e_act.rd            = RdE;
    end

    task automatic check(input string name, input stage_t act, input stage_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_counters(input string name);
`ifdef IDEX_PERF_CNT_EN
        check_int({name, " bubble_cnt"}, int'(BubbleCntE), bub_m);
        check_int({name, " stall_cnt"}, int'(StallCntE), stl_m);
`else
        check_int({name, " no_counters"}, 0, bub_m * 0);
`endif
    endtask

    // Reference behaviour: flush clears, stall holds, otherwise load with the
    // commit-type controls squashed when the incoming slot is invalid.
    task automatic model_edge(input logic s, input logic f, input stage_t din);
        if (f) begin
            m = '0;
            if (bub_m < CNT_MAX) bub_m++;
        end else if (s) begin
            if (stl_m < CNT_MAX) stl_m++;
        end else begin
            m = din;
            if (!din.valid) begin
                m.reg_write = 1'b0;
                m.mem_write = 1'b0;
                m.branch    = 1'b0;
                m.jump      = 1'b0;
            end
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic s, input logic f, input stage_t din);
        stall = s;
        flush = f;
        d     = din;
        @(posedge clk);
        #1;
        model_edge(s, f, din);
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        m     = '0;
        bub_m = 0;
        stl_m = 0;
    endtask

    function automatic stage_t rand_stage();
        stage_t r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r.valid = ($urandom_range(0, 4) != 0);
        return r;
    endfunction

    vec_t   vecs[5];
    stage_t held;
    stage_t zero_w;

    initial begin
        zero_w = '0;

        // Directed vector table, applied back-to-back after reset.
        vecs[0].stall = 1'b0; vecs[0].flush = 1'b0;
        vecs[0].d = '0;
        vecs[0].d.valid = 1'b1; vecs[0].d.reg_write = 1'b1; vecs[0].d.result_src = 3'b001;
        vecs[0].d.rd1 = 32'h1234_5678; vecs[0].d.rd = 5'd7;
        vecs[0].exp = vecs[0].d;

        vecs[1].stall = 1'b1; vecs[1].flush = 1'b0;
        vecs[1].d = '0;
        vecs[1].d.valid = 1'b1; vecs[1].d.mem_write = 1'b1;
        vecs[1].d.rd2 = 32'hDEAD_BEEF; vecs[1].d.rd = 5'd9;
        vecs[1].exp = vecs[0].exp;

        vecs[2].stall = 1'b1; vecs[2].flush = 1'b1;
        vecs[2].d = '0;
        vecs[2].d.valid = 1'b1; vecs[2].d.mem_write = 1'b1; vecs[2].d.rd = 5'd3;
        vecs[2].d.pc = 32'h0000_0040;
        vecs[2].exp = '0;

        vecs[3].stall = 1'b0; vecs[3].flush = 1'b0;
        vecs[3].d = '0;
        vecs[3].d.valid = 1'b0; vecs[3].d.reg_write = 1'b1; vecs[3].d.jump = 1'b1;
        vecs[3].d.branch = 1'b1; vecs[3].d.mem_write = 1'b1; vecs[3].d.alu_src = 1'b1;
        vecs[3].d.imm_ext = 32'h0000_0ABC; vecs[3].d.rd = 5'd5;
        vecs[3].exp = '0;
        vecs[3].exp.alu_src = 1'b1; vecs[3].exp.imm_ext = 32'h0000_0ABC; vecs[3].exp.rd = 5'd5;

        vecs[4].stall = 1'b0; vecs[4].flush = 1'b0;
        vecs[4].d = {32'hA5A5_0F0F, 32'h1111_2222, 32'h3333_4444,
                     32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
        vecs[4].d.valid = 1'b1;
        vecs[4].exp = vecs[4].d;

        stall = 1'b0;
        flush = 1'b0;
        d     = '0;
        async_reset();
        #10;
        check("reset_state", e_act, zero_w);
        check_counters("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(vecs[i].stall, vecs[i].flush, vecs[i].d);
            check($sformatf("vec%0d", i), e_act, vecs[i].exp);
        end

        // Three stall edges with changing inputs: E must not move.
        held = vecs[4].exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, rand_stage());
            check($sformatf("stall_hold%0d", i), e_act, held);
        end

        // Asynchronous reset mid-cycle with non-zero outputs.
        #2;
        async_reset();
        check("async_reset_midcycle", e_act, zero_w);
        check_counters("async_reset");
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), rand_stage());
            check($sformatf("rand%0d", i), e_act, m);
        end
        check_counters("rand_end");

`ifdef IDEX_PERF_CNT_EN
        // Counter saturation and stall counting from a clean reset.
        #2;
        async_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(($urandom_range(0, 1) == 1), 1'b1, rand_stage());
        end
        check_int("bubble_saturated", int'(BubbleCntE), 15);
        check_int("stall_after_flush", int'(StallCntE), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, rand_stage());
        end
        check_int("stall_cnt5", int'(StallCntE), 5);
        check_int("bubble_still_sat", int'(BubbleCntE), 15);
        check("after_cnt_seq", e_act, zero_w);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
